// File: rtl/bpm_pkg.sv
// Shared types and helpers for the BPM front end (onset detection and
// autocorrelation stages).
//   onset_state_t : onset detector FSM states
//   Q2_SHIFT      : fractional bits of Q2 threshold multipliers
//   sat_add       : unsigned add clamped to a caller-supplied ceiling
package bpm_pkg;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        ARMED   = 2'd1,
        REFRACT = 2'd2
    } onset_state_t;

    localparam int Q2_SHIFT = 2;

    // Operands are zero-extended by the caller; the 65-bit sum cannot wrap.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] lim);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage

// File: rtl/spectral_flux_onset_if.sv
// Frame-energy in / flux-and-onset out bundle for one band of the onset
// detector.
//   energy_valid, energy_in : frame energy strobe and value (producer -> detector)
//   flux_valid, flux_out    : rectified flux strobe and value (detector -> consumer)
//   beat_valid              : onset flag, qualified by flux_valid
//   flux_mean               : running mean of the flux history
interface spectral_flux_onset_if #(
    parameter int E_W = 32,
    parameter int W   = 32
);
    logic           energy_valid;
    logic [E_W-1:0] energy_in;
    logic           flux_valid;
    logic [W-1:0]   flux_out;
    logic           beat_valid;
    logic [W-1:0]   flux_mean;

    modport master (
        output energy_valid, energy_in,
        input  flux_valid, flux_out, beat_valid, flux_mean
    );

    modport slave (
        input  energy_valid, energy_in,
        output flux_valid, flux_out, beat_valid, flux_mean
    );
endinterface

// File: rtl/flux_history_ring.sv
// Circular buffer of the last HIST_LEN flux values with an incrementally
// maintained sum of its contents.
//   clk, reset  : clock, asynchronous active-high reset
//   i_push      : insert i_data, evicting the oldest entry
//   i_data      : flux value to insert
//   o_sum       : sum of all entries (registered)
//   o_fill_done : high when the current push completes, or an earlier push
//                 has completed, the first pass through the buffer
module flux_history_ring #(
    parameter int W        = 32,
    parameter int HIST_LEN = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    output logic [W+$clog2(HIST_LEN)-1:0] o_sum,
    output logic                         o_fill_done
);
    localparam int L = $clog2(HIST_LEN);

    logic [W-1:0]   r_mem [HIST_LEN];
    logic [L-1:0]   r_ptr;
    logic [W+L-1:0] r_sum;
    logic           r_filled;
    logic           w_last_slot;

    assign w_last_slot = (r_ptr == L'(HIST_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HIST_LEN; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr    <= '0;
            r_sum    <= '0;
            r_filled <= 1'b0;
        end else if (i_push) begin
            r_mem[r_ptr] <= i_data;
            // Power-of-two depth: the pointer wraps by natural overflow.
            r_ptr        <= r_ptr + L'(1);
            // L guard bits hold HIST_LEN full-scale entries, so no overflow.
            r_sum        <= r_sum + (W+L)'(i_data) - (W+L)'(r_mem[r_ptr]);
            r_filled     <= r_filled | w_last_slot;
        end
    end

    assign o_sum       = r_sum;
    assign o_fill_done = r_filled | w_last_slot;

endmodule

// File: rtl/spectral_flux_onset.sv
// Per-band onset detector: converts frame energies into half-wave-rectified
// spectral flux and flags frames whose flux exceeds an adaptive threshold
// derived from the running mean of recent flux.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of spectral_flux_onset_if
//                (energy_valid/energy_in in; flux_valid/flux_out/beat_valid/
//                flux_mean out). Outputs follow a strobe by two cycles.
module spectral_flux_onset
    import bpm_pkg::*;
#(
    parameter int E_W            = 32,
    parameter int W              = 32,
    parameter int HIST_LEN       = 16,
    parameter int THRESH_MUL     = 6,
    parameter int MIN_FLUX       = 64,
    parameter int REFRACT_FRAMES = 4
) (
    input logic                 clk,
    input logic                 reset,
    spectral_flux_onset_if.slave bus
);
    localparam int L     = $clog2(HIST_LEN);
    localparam int SUM_W = W + L;
    localparam int CNT_W = (REFRACT_FRAMES > 0) ? $clog2(REFRACT_FRAMES + 1) : 1;
    localparam logic [63:0] FLUX_MAX = (64'd1 << W) - 64'd1;

    // ---- stage 1: rectified first difference of energy ----
    logic [E_W-1:0] r_prev_energy;
    logic [E_W-1:0] w_diff;
    logic [W-1:0]   r_flux_p1;
    logic           r_vld_p1;

    assign w_diff = bus.energy_in - r_prev_energy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_energy <= '0;
            r_flux_p1     <= '0;
            r_vld_p1      <= 1'b0;
        end else begin
            r_vld_p1 <= bus.energy_valid;
            if (bus.energy_valid) begin
                r_prev_energy <= bus.energy_in;
                r_flux_p1     <= (bus.energy_in > r_prev_energy) ? W'(w_diff) : '0;
            end
        end
    end

    // ---- stage 2: threshold, history insert, onset FSM ----
    logic [SUM_W-1:0] w_sum;
    logic             w_fill_done;
    logic [W-1:0]     w_mean;
    logic [W+3:0]     w_prod;
    logic [W+3:0]     w_scaled;
    logic [63:0]      w_thresh;
    logic             w_cand;

    flux_history_ring #(
        .W        (W),
        .HIST_LEN (HIST_LEN)
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_vld_p1),
        .i_data      (r_flux_p1),
        .o_sum       (w_sum),
        .o_fill_done (w_fill_done)
    );

    // Mean comes from the registered sum, i.e. before this frame is inserted.
    assign w_mean   = W'(w_sum >> L);
    assign w_prod   = (W+4)'(w_mean) * (W+4)'(THRESH_MUL);
    assign w_scaled = w_prod >> Q2_SHIFT;
    assign w_thresh = sat_add(64'(w_scaled), 64'(MIN_FLUX), FLUX_MAX);
    assign w_cand   = 64'(r_flux_p1) > w_thresh;

    onset_state_t   r_state;
    onset_state_t   w_next;
    logic [CNT_W-1:0] r_cnt;
    logic           w_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WARMUP;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WARMUP: begin
                if (r_vld_p1 && w_fill_done) w_next = ARMED;
            end
            ARMED: begin
                if (r_vld_p1 && w_cand) w_next = (REFRACT_FRAMES == 0) ? ARMED : REFRACT;
            end
            REFRACT: begin
                // The frame that takes the counter from 1 to 0 is still
                // suppressed; evaluation resumes on the following frame.
                if (r_vld_p1 && (r_cnt == CNT_W'(1))) w_next = ARMED;
            end
            default: w_next = WARMUP;
        endcase
    end

    always_comb begin
        w_beat = r_vld_p1 && (r_state == ARMED) && w_cand;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_vld_p1) begin
            if (w_beat) begin
                r_cnt <= CNT_W'(REFRACT_FRAMES);
            end else if (r_state == REFRACT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // ---- stage 2 output registers ----
    logic         r_vld_p2;
    logic [W-1:0] r_flux_p2;
    logic         r_beat_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p2  <= 1'b0;
            r_flux_p2 <= '0;
            r_beat_p2 <= 1'b0;
        end else begin
            r_vld_p2  <= r_vld_p1;
            r_beat_p2 <= w_beat;
            if (r_vld_p1) r_flux_p2 <= r_flux_p1;
        end
    end

    assign bus.flux_valid = r_vld_p2;
    assign bus.flux_out   = r_flux_p2;
    assign bus.beat_valid = r_beat_p2;
    assign bus.flux_mean  = w_mean;

endmodule

// File: tb/tb_spectral_flux_onset.sv
// Bench for spectral_flux_onset: one default 32-bit instance and one 16-bit
// instance with a large multiplier so the threshold saturates. Both are
// compared every cycle against a frame-level reference model.
module tb_spectral_flux_onset;
    localparam int HL = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spectral_flux_onset_if #(.E_W(32), .W(32)) bus32 ();
    spectral_flux_onset_if #(.E_W(16), .W(16)) bus16 ();

    spectral_flux_onset #(
        .E_W(32), .W(32), .HIST_LEN(HL), .THRESH_MUL(6), .MIN_FLUX(64), .REFRACT_FRAMES(4)
    ) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    spectral_flux_onset #(
        .E_W(16), .W(16), .HIST_LEN(HL), .THRESH_MUL(15), .MIN_FLUX(64), .REFRACT_FRAMES(4)
    ) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model (per instance k) ----------------
    int     m_w   [2] = '{32, 16};
    int     m_mul [2] = '{6, 15};
    longint m_prev[2];
    longint m_hist[2][HL];
    int     m_wp  [2];
    int     m_nfr [2];
    int     m_refr[2];

    bit     e1_v[2], e2_v[2], e1_b[2], e2_b[2];
    longint e1_f[2], e2_f[2], e1_m[2], e2_m[2], cur_mean[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev[k] = 0; m_wp[k] = 0; m_nfr[k] = 0; m_refr[k] = 0;
            for (int i = 0; i < HL; i++) m_hist[k][i] = 0;
            e1_v[k] = 0; e2_v[k] = 0; e1_b[k] = 0; e2_b[k] = 0;
            e1_f[k] = 0; e2_f[k] = 0; e1_m[k] = 0; e2_m[k] = 0;
            cur_mean[k] = 0;
        end
    endtask

    function automatic longint hist_mean(input int k);
        longint s = 0;
        for (int i = 0; i < HL; i++) s += m_hist[k][i];
        return s / HL;
    endfunction

    task automatic model_step(input int k, input longint e,
                              output longint f, output bit b, output longint m);
        longint wmax, thr;
        wmax = (longint'(1) << m_w[k]) - 1;
        f = (e > m_prev[k]) ? e - m_prev[k] : 0;
        m_prev[k] = e;
        thr = (hist_mean(k) * m_mul[k]) / 4 + 64;
        if (thr > wmax) thr = wmax;
        b = 0;
        if (m_nfr[k] >= HL) begin
            if (m_refr[k] > 0) m_refr[k]--;
            else if (f > thr) begin
                b = 1;
                m_refr[k] = 4;
            end
        end
        m_hist[k][m_wp[k]] = f;
        m_wp[k] = (m_wp[k] + 1) % HL;
        m_nfr[k]++;
        m_mean_dummy(k, m);
    endtask

    task automatic m_mean_dummy(input int k, output longint m);
        m = hist_mean(k);
    endtask

    // ---------------- per-cycle compare and drive ----------------
    task automatic check_outputs(input int k, input logic fv, input logic [63:0] fo,
                                 input logic bv, input logic [63:0] fm);
        string nm;
        nm = (k == 0) ? "w32" : "w16";
        if (e2_v[k]) cur_mean[k] = e2_m[k];
        chk({nm, ".flux_valid"}, 64'(fv), 64'(e2_v[k]));
        chk({nm, ".beat_valid"}, 64'(bv), 64'(e2_b[k]));
        if (e2_v[k]) chk({nm, ".flux_out"}, fo, e2_f[k]);
        chk({nm, ".flux_mean"}, fm, cur_mean[k]);
    endtask

    task automatic cycle(input bit v0, input longint en0, input bit v1, input longint en1);
        longint f, m;
        bit b;
        @(negedge clk);
        check_outputs(0, bus32.flux_valid, 64'(bus32.flux_out), bus32.beat_valid, 64'(bus32.flux_mean));
        check_outputs(1, bus16.flux_valid, 64'(bus16.flux_out), bus16.beat_valid, 64'(bus16.flux_mean));
        for (int k = 0; k < 2; k++) begin
            e2_v[k] = e1_v[k]; e2_b[k] = e1_b[k]; e2_f[k] = e1_f[k]; e2_m[k] = e1_m[k];
            e1_v[k] = 0; e1_b[k] = 0;
        end
        if (v0) begin
            model_step(0, en0 & 64'hFFFF_FFFF, f, b, m);
            e1_v[0] = 1; e1_f[0] = f; e1_b[0] = b; e1_m[0] = m;
        end
        if (v1) begin
            model_step(1, en1 & 64'hFFFF, f, b, m);
            e1_v[1] = 1; e1_f[1] = f; e1_b[1] = b; e1_m[1] = m;
        end
        bus32.energy_valid = v0;
        bus32.energy_in    = en0[31:0];
        bus16.energy_valid = v1;
        bus16.energy_in    = en1[15:0];
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".w32.flux_valid"}, 64'(bus32.flux_valid), 64'd0);
        chk({tag, ".w32.flux_out"},   64'(bus32.flux_out),   64'd0);
        chk({tag, ".w32.beat_valid"}, 64'(bus32.beat_valid), 64'd0);
        chk({tag, ".w32.flux_mean"},  64'(bus32.flux_mean),  64'd0);
        chk({tag, ".w16.flux_valid"}, 64'(bus16.flux_valid), 64'd0);
        chk({tag, ".w16.flux_out"},   64'(bus16.flux_out),   64'd0);
        chk({tag, ".w16.beat_valid"}, 64'(bus16.beat_valid), 64'd0);
        chk({tag, ".w16.flux_mean"},  64'(bus16.flux_mean),  64'd0);
    endtask

    // Call right after a cycle() that launched a frame on the 32-bit instance:
    // reset lands between edges while that frame is on the outputs.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #1;
        bus32.energy_valid = 1'b0;
        bus16.energy_valid = 1'b0;
        @(posedge clk);
        #2;
        chk({tag, ".pre.flux_valid"}, 64'(bus32.flux_valid), 64'(e1_v[0]));
        chk({tag, ".pre.flux_out"},   64'(bus32.flux_out),   e1_f[0]);
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    longint e0, e1;

    initial begin
        reset = 1'b1;
        bus32.energy_valid = 1'b0;
        bus32.energy_in    = '0;
        bus16.energy_valid = 1'b0;
        bus16.energy_in    = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Warm-up: flat energy, only the first frame has flux.
        repeat (20) cycle(1, 1000, 0, 0);
        // Onset from the quiet, armed state.
        cycle(1, 2000, 0, 0);
        repeat (20) cycle(1, 2000, 0, 0);
        // Back-to-back rising steps: beats on frames 1 and 6 only.
        for (int i = 1; i <= 6; i++) cycle(1, 2000 + 1000 * i, 0, 0);
        // Falling energy rectifies to zero.
        cycle(1, 5000, 0, 0);
        cycle(1, 100, 0, 0);
        // Mean of exactly 1000, then a flux equal to / one above threshold.
        e0 = 100;
        repeat (16) begin e0 += 1000; cycle(1, e0, 0, 0); end
        e0 += 1564; cycle(1, e0, 0, 0);
        repeat (16) begin e0 += 1000; cycle(1, e0, 0, 0); end
        e0 += 1565; cycle(1, e0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);

        // Asynchronous reset with a frame in flight, then first-frame flux.
        cycle(1, e0 + 500, 0, 0);
        mid_reset("midreset");
        cycle(1, 777, 0, 0);
        cycle(1, 700, 0, 0);

        // Saturated threshold on the 16-bit instance.
        for (int i = 0; i < 40; i++) cycle(0, 0, 1, (i % 2 == 0) ? 65535 : 0);
        repeat (3) cycle(0, 0, 0, 0);

        // Randomized traffic on both instances.
        e0 = 0;
        e1 = 0;
        for (int i = 0; i < 600; i++) begin
            int r0, r1;
            bit v0, v1;
            r0 = $urandom_range(0, 9);
            r1 = $urandom_range(0, 9);
            if (r0 == 0)      e0 = 64'($urandom);
            else if (r0 < 5)  e0 = (e0 + 64'($urandom_range(0, 4000))) & 64'hFFFF_FFFF;
            else              e0 = (e0 > 3000) ? e0 - 64'($urandom_range(0, 3000)) : e0;
            if (r1 == 0)      e1 = 64'($urandom_range(0, 65535));
            else if (r1 < 5)  e1 = (e1 + 64'($urandom_range(0, 9000))) & 64'hFFFF;
            else              e1 = (e1 > 4000) ? e1 - 64'($urandom_range(0, 4000)) : e1;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            if (i == 300) begin
                cycle(1, e0, v1, e1);
                mid_reset("randreset");
            end else begin
                cycle(v0, e0, v1, e1);
            end
        end
        repeat (3) cycle(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
